// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NREQ requesters. The memory command is registered one cycle after grant.
// Load data returns 1+MEM_LATENCY cycles after grant. Returns cannot be stalled, and unaccepted requests must be held by the requester.
module data_mem_arbiter #(
  parameter int NREQ        = 5,
  parameter int DEPTH       = 131072,
  parameter int AW          = $clog2(DEPTH),
  parameter int MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*32-1:0] addr,
  input  logic [NREQ*32-1:0] din,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [31:0]        dout,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [31:0]        mem_din,
  input  logic [31:0]        mem_dout
);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NST = MEM_LATENCY + 1;

  logic [PW-1:0] ptr;
  logic          win_vld;
  logic [PW-1:0] win_idx;
  int            cand;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_din;
  logic          sel_we;
  logic          own_vld [NST];
  logic [PW-1:0] own_idx [NST];
  logic          unused_addr_hi;

  // Rotating priority search: first requester at or after ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!win_vld && (i == cand) && req[i]) begin
          win_vld = 1'b1;
          win_idx = PW'(i);
        end
      end
    end
    if (rst) win_vld = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (win_vld) gnt[win_idx] = 1'b1;
  end

  always_comb begin
    sel_addr       = '0;
    sel_din        = '0;
    sel_we         = 1'b0;
    unused_addr_hi = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      unused_addr_hi = unused_addr_hi ^ (^addr[32*i+AW +: 32-AW]);
      if (win_idx == PW'(i)) begin
        sel_addr = addr[32*i +: AW];
        sel_din  = din[32*i +: 32];
        sel_we   = we[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      for (int s = 0; s < NST; s++) begin
        own_vld[s] <= 1'b0;
        own_idx[s] <= '0;
      end
    end else begin
      mem_en <= win_vld;
      mem_we <= win_vld & sel_we;
      if (win_vld) begin
        ptr      <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
        mem_addr <= sel_addr;
        mem_din  <= sel_din;
      end
      // Owner of each in-flight load rides alongside the memory latency.
      own_vld[0] <= win_vld & ~sel_we;
      own_idx[0] <= win_idx;
      for (int s = 1; s < NST; s++) begin
        own_vld[s] <= own_vld[s-1];
        own_idx[s] <= own_idx[s-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    dout   = '0;
    if (!rst && own_vld[NST-1]) begin
      rvalid[own_idx[NST-1]] = 1'b1;
      dout                   = mem_dout;
    end
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single port of the data memory (DATA_MEM_DEPTH words) between the main core and SUBCORE_NUM subcores.
- Each requester presents one load or store per transaction using the addr/din/we triple.
- The arbiter picks one requester per cycle using round-robin and registers the command to the memory.
- It tracks in-flight loads and returns read data to the requester that issued each load.

Parameters:
NREQ, 5, number of requesters (SUBCORE_NUM + 1); index 0 = main core, 1..NREQ-1 = subcores
DEPTH, 131072, data memory depth in words (DATA_MEM_DEPTH)
AW, 17, memory address width (log2 DEPTH)
MEM_LATENCY, 2, cycles from mem_en high to mem_dout valid

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NREQ  per-requester request valid; held until granted
we  in  NREQ  per-requester write enable (1 = store, 0 = load)
addr  in  NREQ*32  per-requester word address; slice i = [32*i+31:32*i]
din  in  NREQ*32  per-requester store data; same slicing
gnt  out  NREQ  one-hot grant, combinational, same cycle as accepted req
rvalid  out  NREQ  one-hot load-data-valid pulse
dout  out  32  load data, broadcast; valid for the requester whose rvalid bit is high
mem_en  out  1  registered memory enable
mem_we  out  1  registered memory write enable
mem_addr  out  AW  registered memory address
mem_din  out  32  registered memory write data
mem_dout  in  32  memory read data

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - ptr = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
  - rvalid = 0, dout = 0.
  - Owner pipeline cleared.
- Arbitration (combinational):
  - Search req starting at index ptr, ascending with wrap-around at NREQ-1 to 0.
  - The first set bit i wins and gnt[i] = 1. At most one gnt bit is set.
  - gnt is 0 while rst = 1.
- Handshake:
  - A transaction is accepted in a cycle where req[i] & gnt[i].
  - The requester may change addr/din/we or drop req on the next cycle.
  - A requester that is not granted must hold req, addr, din and we stable. The arbiter does not latch unaccepted requests.
- Pointer update:
  - On grant to i, ptr <= (i+1) mod NREQ.
  - With no req, ptr holds.
  - A requester held continuously is granted within NREQ cycles.
- Command stage: in a grant cycle, the next edge loads:
  - mem_en = 1, mem_we = we[i], mem_addr = addr_i[AW-1:0] (upper 32-AW bits ignored), mem_din = din_i.
  - With no grant, mem_en = 0 and mem_we = 0. mem_addr and mem_din hold.
- Read return:
  - A load granted in cycle T drives mem_en in T+1.
  - mem_dout is sampled valid in T+1+MEM_LATENCY.
  - In that cycle rvalid[i] = 1 (one cycle) and dout = mem_dout (combinational pass-through).
  - Owner tracking is a MEM_LATENCY+1-deep shift register of {valid, owner index}, loaded with valid = grant & ~we.
  - Stores produce no rvalid.
- Throughput and ordering:
  - One access per cycle, fully pipelined.
  - Back-to-back loads from different requesters return in grant order, one per cycle.
  - Accesses are serviced in grant order, so a load granted after a store to the same address returns the stored value.
- Simultaneous events: a new grant and an rvalid for an older load may occur in the same cycle, including for the same requester. Both are independent.
- Reset mid-operation: in-flight loads are discarded, no rvalid is emitted for them, and ptr returns to 0.
- No backpressure on read return: the requester must accept dout when rvalid is high.

Test Plan:
- Reset then single load: store 0xDEADBEEF to 0x00010 via req[0]; later load 0x00010 via req[2]. Require gnt[2] same cycle and rvalid[2] = 1 with dout = 0xDEADBEEF exactly 1+MEM_LATENCY = 3 cycles after the grant cycle. Other rvalid bits stay 0.
- All five req held high from reset: grants in order 0,1,2,3,4,0. Each requester is granted exactly once per 5 cycles. mem_en = 1 every cycle.
- ptr = 3 and req = 5'b00011: gnt = 5'b00001, then ptr = 1. Next cycle with req still 5'b00010: gnt = 5'b00010.
- Address truncation: load with addr = 0xFFFE0005 -> mem_addr = 17'h00005.
- Pipelined mixed traffic: load by 1, store by 2, load by 3 on consecutive cycles. Require rvalid[1] and rvalid[3] in consecutive-but-one cycles matching their grant offsets. No rvalid for 2.
- Assert rst one cycle after a load grant: no rvalid follows, mem_en = 0, and the next grant search starts at index 0.
